sr_cell_sequencer: RTL and testbench

Sequencing controller for the NAND basic cell (active-low set/reset inputs, Q1/Q2 outputs). It shares the cell between a set requester and a clear requester and drives the cell's s/r inputs with timed, non-overlapping low pulses, so that s and r are never 0 together. After each write it checks the cell's Q1 feedback and flags any mismatch. It sits between user logic (buttons/FSMs) and the NAND cell instance on the board.

---
 rtl/sr_cell_sequencer.sv | 136 +++++++++++++
 tb/tb_sr_cell_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cell_sequencer.sv
// sr_cell_sequencer
//   Shares one NAND basic cell (active-low s/r) between a set requester and a
//   clear requester. Each write drives exactly one of s_n/r_n low for
//   PULSE_CYCLES, then holds both high for GAP_CYCLES, then checks the cell's
//   Q1 feedback and strobes the matching ack for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   set_req    level request to set the cell (held until set_ack)
//   clr_req    level request to clear the cell (held until clr_ack)
//   q_fb       Q1 feedback from the cell
//   s_n, r_n   active-low pulses to the cell; never both low
//   set_ack    one-cycle completion strobe for a set write
//   clr_ack    one-cycle completion strobe for a clear write
//   busy       high whenever the sequencer is not idle
//   err        sticky feedback-mismatch flag, cleared only by reset
//   last_grant 0 = last write was set, 1 = last write was clear
module sr_cell_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic err,
    output logic last_grant
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Counters run down to zero, so load one less than the cycle count.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grant_clr;   // type of the write in flight
    logic             r_s_n;
    logic             r_r_n;
    logic             r_set_ack;
    logic             r_clr_ack;
    logic             r_busy;
    logic             r_err;
    logic             r_last_grant;

    logic w_grant_any;
    logic w_grant_clr;

    // With both requests pending, the type not granted last time wins.
    assign w_grant_any = set_req | clr_req;
    assign w_grant_clr = clr_req & (~set_req | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_grant_clr  <= 1'b0;
            r_s_n        <= 1'b1;
            r_r_n        <= 1'b1;
            r_set_ack    <= 1'b0;
            r_clr_ack    <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_set_ack <= 1'b0;
            r_clr_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_state      <= PULSE;
                        r_busy       <= 1'b1;
                        r_grant_clr  <= w_grant_clr;
                        r_last_grant <= w_grant_clr;
                        r_s_n        <= w_grant_clr;
                        r_r_n        <= ~w_grant_clr;
                        r_cnt        <= PULSE_LOAD;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= GAP;
                        r_s_n   <= 1'b1;
                        r_r_n   <= 1'b1;
                        r_cnt   <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        r_set_ack <= ~r_grant_clr;
                        r_clr_ack <= r_grant_clr;
                        // A set must leave Q1=1, a clear Q1=0.
                        if (q_fb != ~r_grant_clr)
                            r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_s_n   <= 1'b1;
                    r_r_n   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_n        = r_s_n;
    assign r_n        = r_r_n;
    assign set_ack    = r_set_ack;
    assign clr_ack    = r_clr_ack;
    assign busy       = r_busy;
    assign err        = r_err;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_sr_cell_sequencer.sv
module tb_sr_cell_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic s_n, r_n, set_ack, clr_ack, busy, err, last_grant;

    int total = 0;
    int bad = 0;

    // Behavioural NAND cell: low s sets Q1, low r clears it, both high holds.
    logic q1 = 1'b0;
    logic force_q0 = 1'b0;
    logic overlap_seen = 1'b0;

    assign q_fb = force_q0 ? 1'b0 : q1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_n === 1'b0 && r_n === 1'b1) q1 <= 1'b1;
        else if (r_n === 1'b0 && s_n === 1'b1) q1 <= 1'b0;
        if (s_n === 1'b0 && r_n === 1'b0) overlap_seen <= 1'b1;
    end

    sr_cell_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .q_fb(q_fb), .s_n(s_n), .r_n(r_n), .set_ack(set_ack),
        .clr_ack(clr_ack), .busy(busy), .err(err), .last_grant(last_grant)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_req = 1'b1;
        clr_req = 1'b1;
        tick();
        tick();
        total++;
        if ({s_n, r_n, busy, set_ack, clr_ack, err, last_grant} !== 7'b1100001) begin
            bad++;
            $display("FAIL reset_state: got s_n,r_n,busy,sack,cack,err,lg=%b want 1100001",
                     {s_n, r_n, busy, set_ack, clr_ack, err, last_grant});
        end
        rst_n = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_set;
        logic exp_s;
        set_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_s = (c <= 4) ? 1'b0 : 1'b1;
            total++;
            if ({s_n, r_n, set_ack, clr_ack, busy} !== {exp_s, 1'b1, (c == 7), 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL set_seq cycle %0d: s_n,r_n,sack,cack,busy=%b want %b", c,
                         {s_n, r_n, set_ack, clr_ack, busy}, {exp_s, 1'b1, (c == 7), 1'b0, 1'b1});
            end
            if (c == 7) set_req = 1'b0;
        end
        tick();
        total++;
        if ({busy, set_ack, q1, err, last_grant} !== 5'b00100) begin
            bad++;
            $display("FAIL set_after: busy,sack,q1,err,lg=%b want 00100",
                     {busy, set_ack, q1, err, last_grant});
        end
    endtask

    task automatic test_both;
        logic exp_s, exp_r, exp_sa, exp_ca;
        do_reset();
        overlap_seen = 1'b0;
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_s  = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
            exp_r  = (c >= 9 && c <= 12) ? 1'b0 : 1'b1;
            exp_sa = (c == 7);
            exp_ca = (c == 15);
            total++;
            if ({s_n, r_n, set_ack, clr_ack, busy} !== {exp_s, exp_r, exp_sa, exp_ca, (c != 8)}) begin
                bad++;
                $display("FAIL both_seq cycle %0d: s_n,r_n,sack,cack,busy=%b want %b", c,
                         {s_n, r_n, set_ack, clr_ack, busy}, {exp_s, exp_r, exp_sa, exp_ca, (c != 8)});
            end
            if (set_ack) set_req = 1'b0;
            if (clr_ack) clr_req = 1'b0;
        end
        tick();
        total++;
        if ({q1, last_grant, err, overlap_seen} !== 4'b0100) begin
            bad++;
            $display("FAIL both_after: q1,lg,err,overlap=%b want 0100",
                     {q1, last_grant, err, overlap_seen});
        end
    endtask

    task automatic test_round_robin;
        int waited;
        do_reset();
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int w = 0; w < 4; w++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!set_ack && !clr_ack && waited < 30);
            total++;
            if ({set_ack, clr_ack, last_grant} !== {(w % 2 == 0), (w % 2 == 1), (w % 2 == 1)}) begin
                bad++;
                $display("FAIL rr_write %0d: sack,cack,lg=%b want %b (waited %0d)", w,
                         {set_ack, clr_ack, last_grant},
                         {(w % 2 == 0), (w % 2 == 1), (w % 2 == 1)}, waited);
            end
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_err;
        int waited;
        do_reset();
        force_q0 = 1'b1;
        set_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            total++;
            if (err !== (c == 7)) begin
                bad++;
                $display("FAIL err_set cycle %0d: err=%b want %b", c, err, (c == 7));
            end
            if (c == 7) set_req = 1'b0;
        end
        force_q0 = 1'b0;
        clr_req = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!clr_ack && waited < 30);
        clr_req = 1'b0;
        total++;
        if ({clr_ack, err, q1} !== 3'b110) begin
            bad++;
            $display("FAIL err_sticky: cack,err,q1=%b want 110", {clr_ack, err, q1});
        end
        tick();
        do_reset();
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared: err=%b want 0", err);
        end
    endtask

    task automatic test_abort;
        logic ack_seen;
        do_reset();
        clr_req = 1'b1;
        tick();
        tick();
        total++;
        if ({r_n, busy} !== 2'b01) begin
            bad++;
            $display("FAIL abort_pulse: r_n,busy=%b want 01", {r_n, busy});
        end
        rst_n = 1'b0;
        clr_req = 1'b0;
        tick();
        total++;
        if ({s_n, r_n, busy, clr_ack} !== 4'b1100) begin
            bad++;
            $display("FAIL abort_reset: s_n,r_n,busy,cack=%b want 1100", {s_n, r_n, busy, clr_ack});
        end
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (clr_ack || set_ack || busy) ack_seen = 1'b1;
        end
        total++;
        if (ack_seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_ack: activity after abort=%b want 0", ack_seen);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_both();
        test_round_robin();
        test_err();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
